foo_pipe_arbiter: RTL
=====================

# foo_pipe_arbiter

Round-robin scheduler that shares one instance of the stitched `foo` pipeline among `NUM_REQ` requesters. Each cycle it grants at most one requester and drives that requester's operand into the pipeline with `input_valid`. Because `foo` carries no tag and does not export its valid, the block keeps a shadow tag line matched to the pipeline latency. It uses that line to route each result back to the requester that issued it. The block sits between the client ports and the `foo` top-level (`clk`, `rst`, `input_valid`, `x`, `out`).

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `DATA_WIDTH`, default 32: operand/result width; must equal the `foo` `x`/`out` width.
- `LATENCY`, default 3: cycles from `input_valid`/`x` sampled to matching `out`; must be ≥1.
- `IDW`: derived, equal to `max(1, $clog2(NUM_REQ))`. Not overridable.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `enable`  in  1  1 = grants allowed; 0 = no new issue, in-flight ops drain.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot-or-zero grant; transfer when `req_valid[i] & req_ready[i]`.
- `pipe_input_valid`  out  1  to `foo.input_valid`.
- `pipe_x`  out  DATA_WIDTH  to `foo.x`.
- `pipe_out`  in  DATA_WIDTH  from `foo.out`.
- `resp_valid`  out  NUM_REQ  one-hot-or-zero result strobe; no backpressure.
- `resp_data`  out  DATA_WIDTH  result, shared by all requesters; meaningful only when some `resp_valid` bit = 1.
- `inflight`  out  $clog2(LATENCY+1)  count of issued, not-yet-returned ops.
- `busy`  out  1  `inflight != 0`.

## Operation
Grant logic:
- Grant logic is combinational from `req_valid`, `enable` and the pointer `last_grant` (IDW bits).
- The grant goes to the first i with `req_valid[i]=1`, scanning `last_grant+1, last_grant+2, …` modulo NUM_REQ.
- No grant when `enable=0` or no request is pending.
- `req_ready` does not depend on `req_valid[i]` of the granted requester beyond the scan. Requesters must not make `req_valid` depend on `req_ready`.

Issue:
- Issue occurs when a grant exists.
- `pipe_input_valid=1`.
- `pipe_x` = the granted operand.
- When not issuing, `pipe_x=0` and `pipe_input_valid=0`.
- On the issue edge, `last_grant` updates to the granted index. With no issue it holds.

Tag line:
- A LATENCY-deep shift register of {v, id}. Stage 0 loads {issue, grant_id} every cycle; stages advance unconditionally.
- Retire is driven by the tail stage.
  - `resp_valid[id_tail] = v_tail`; all other bits are 0.
  - `resp_data = pipe_out` when `v_tail=1`, else 0.
- Consequence: a result for requester i can appear while requester i is being granted a new op. Both paths are independent.

In-flight counter:
- +1 on issue, −1 on retire.
- Both in the same cycle: unchanged.
- Never exceeds LATENCY; the pipeline accepts one op per cycle, so there is no stall condition.

Arithmetic:
- The block performs no data arithmetic; data passes through unmodified.
- Pointer wrap: NUM_REQ−1 → 0.
- `foo` computes `out = x + 3` mod 2^DATA_WIDTH. Benches use this as the reference model.

## Timing
- Reset values (`rst=0`, asynchronous):
  - `last_grant = NUM_REQ−1`, so requester 0 has first priority.
  - Tag line all v=0.
  - `inflight=0`, `busy=0`, `resp_valid=0`, `resp_data=0`.
  - `req_ready`, `pipe_input_valid` and `pipe_x` follow the combinational rule with `enable` and the reset state. They are 0 while `rst=0`: issue is gated by reset.
- Reset deassertion is synchronized internally (2-flop) before it gates issue. The first grant is therefore possible on the 2nd rising edge after `rst` rises.
- Result latency: an op issued at edge N (`req_valid & req_ready` sampled) returns with `resp_valid` high during the cycle after edge N+LATENCY−1. This is exactly the cycle in which `foo.out` holds it.
- Throughput: 1 op/cycle aggregate. With all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- `enable` 1→0: the grant drops the same cycle. Previously issued ops still retire over the next ≤LATENCY cycles, and `busy` falls the cycle after the last retire edge.
- Reset mid-operation: in-flight ops are discarded and no `resp_valid` is produced for them. The `foo` pipeline contents are don't-care.

## Test plan
- Single op: after reset, `req_valid[2]=1`, `req_data[2]=5` for one transfer.
  - Required: `req_ready=4'b0100`.
  - Exactly LATENCY=3 cycles later, `resp_valid=4'b0100`, `resp_data=8`.
  - `inflight` goes 1,1,1,0.
- Round-robin fairness: all 4 requesters held valid for 12 cycles with operands 100+i.
  - Required grant order 0,1,2,3,0,1,2,3,0,1,2,3.
  - Each requester receives result 103+i three times, each strobe on its own `resp_valid` bit.
- Wrap and skip: only requesters 1 and 3 valid, `last_grant=3` → grants 1,3,1,3.
  - Operand `0xFFFF_FFFF` returns `0x0000_0002`.
- Enable drain: continuous traffic, then `enable=0` for 5 cycles.
  - Required: `req_ready=0` immediately.
  - Exactly 3 further `resp_valid` pulses, then `busy=0`.
  - On re-enable, the grant resumes at `last_grant+1`.
- Reset mid-flight: 3 ops in flight, assert `rst=0` for 1 cycle.
  - Required: `resp_valid` stays 0 for the next 5 cycles, `inflight=0`.
  - After release, requester 0 is granted first on the 2nd edge.
- Simultaneous issue/retire for the same requester: requester 0 alone valid continuously.
  - Required: `inflight` saturates at 3 and holds.
  - `resp_valid[0]` high every cycle from cycle 3 on, with results in issue order.

Source files
------------

// File: rtl/foo_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// foo_pipe_arbiter
//
// Round-robin scheduler that shares one instance of the untagged `foo`
// pipeline among NUM_REQ requesters. Each cycle at most one requester is
// granted, and its operand is driven into the pipeline. A shadow tag line that
// matches the pipeline latency routes each result back to the requester that
// issued it.
//
// Ports:
//   clk               sole clock, rising edge
//   rst               asynchronous reset, active low (0 = in reset)
//   enable            1 = new grants allowed; 0 = no issue, in-flight ops drain
//   req_valid         per-requester operand valid
//   req_data          operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready         one-hot-or-zero grant
//   pipe_input_valid  to foo.input_valid
//   pipe_x            to foo.x (zero when not issuing)
//   pipe_out          from foo.out
//   resp_valid        one-hot-or-zero result strobe, no backpressure
//   resp_data         shared result bus (zero when no strobe)
//   inflight          issued but not yet returned op count
//   busy              inflight != 0
// -----------------------------------------------------------------------------
module foo_pipe_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            pipe_input_valid,
    output logic [DATA_WIDTH-1:0]           pipe_x,
    input  logic [DATA_WIDTH-1:0]           pipe_out,
    output logic [NUM_REQ-1:0]              resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_data,
    output logic [$clog2(LATENCY+1)-1:0]    inflight,
    output logic                            busy
);

    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW  = $clog2(LATENCY + 1);

    // -------------------------------------------------------------------------
    // Reset release synchronizer: issue is held off until the deassertion of
    // rst has passed through two flops, so the first grant is visible after
    // the second rising edge following release.
    // -------------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1] & rst;

    // -------------------------------------------------------------------------
    // Round-robin grant
    // -------------------------------------------------------------------------
    logic [IDW-1:0] last_grant_q;
    logic [IDW-1:0] last_grant_d;
    logic [IDW-1:0] grant_id;
    logic           grant_found;
    logic           issue;

    // Scan last_grant+1, last_grant+2, ... modulo NUM_REQ; first valid wins.
    always_comb begin
        logic [IDW-1:0] idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((32'(last_grant_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign issue = grant_found & enable & run;

    always_comb begin
        last_grant_d = last_grant_q;
        if (issue) begin
            last_grant_d = grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= IDW'(NUM_REQ - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Grant and operand mux toward the pipeline
    always_comb begin
        req_ready        = '0;
        pipe_x           = '0;
        pipe_input_valid = issue;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (issue && (grant_id == IDW'(i))) begin
                req_ready[i] = 1'b1;
                pipe_x       = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Shadow tag line: mirrors the foo pipeline, advancing every cycle.
    // -------------------------------------------------------------------------
    logic           tag_v_q  [LATENCY];
    logic [IDW-1:0] tag_id_q [LATENCY];
    logic           tag_v_d  [LATENCY];
    logic [IDW-1:0] tag_id_d [LATENCY];

    always_comb begin
        tag_v_d[0]  = issue;
        tag_id_d[0] = grant_id;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_v_q[i]  <= 1'b0;
                tag_id_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_v_q[i]  <= tag_v_d[i];
                tag_id_q[i] <= tag_id_d[i];
            end
        end
    end

    // Retire from the tail stage; it is valid exactly while foo.out holds
    // the matching result.
    logic           retire;
    logic [IDW-1:0] retire_id;

    assign retire    = tag_v_q[LATENCY-1];
    assign retire_id = tag_id_q[LATENCY-1];

    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (retire && (retire_id == IDW'(i))) begin
                resp_valid[i] = 1'b1;
            end
        end
        if (retire) begin
            resp_data = pipe_out;
        end
    end

    // -------------------------------------------------------------------------
    // In-flight counter
    // -------------------------------------------------------------------------
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_d;

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, retire})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign inflight = inflight_q;
    assign busy     = (inflight_q != '0);

endmodule
